// File: rtl/timer_pkg.sv
// Shared timer/stopwatch types: FSM states and common-anode 7-segment encoding.
// Pure declarations, no state; no flow control.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Bit order g..a, active-low, digits 0-9.
  localparam logic [6:0] SEG_LUT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [3:0] bcd_sat(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    return (d > 4'd9) ? SEG_BLANK : SEG_LUT[d];
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every CLK_HZ enabled cycles, holds when disabled.
// Tick is combinational from the count; clr overrides en; no flow control.
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD seconds countdown with start/stop edges, expiry pulse/alarm; segments
// combinational from digit regs. COUNTDOWN_ALARM_BLINK_EN adds blinking "00" while expired.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_ones,
  input  logic       start,
  input  logic       stop,
  output logic [6:0] seg1,
  output logic [6:0] seg0,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  state_t     state, state_n;
  logic [3:0] tens, ones, tens_n, ones_n;
  logic       start_prev, stop_prev;
  logic       start_edge, stop_edge;
  logic       done_n;
  logic       tick;

  assign start_edge = start & ~start_prev;
  assign stop_edge  = stop & ~stop_prev;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state == RUN),
    .clr  (load),
    .tick (tick)
  );

  always_comb begin
    state_n = state;
    tens_n  = tens;
    ones_n  = ones;
    done_n  = 1'b0;
    if (load) begin
      state_n = IDLE;
      tens_n  = bcd_sat(preset_tens);
      ones_n  = bcd_sat(preset_ones);
    end else begin
      case (state)
        IDLE: begin
          if (start_edge && !stop_edge && (tens != 4'd0 || ones != 4'd0)) state_n = RUN;
        end
        RUN: begin
          if (tick && (tens != 4'd0 || ones != 4'd0)) begin
            if (ones != 4'd0) begin
              ones_n = ones - 4'd1;
            end else begin
              ones_n = 4'd9;
              tens_n = tens - 4'd1;
            end
          end
          // Expiry outranks a coincident stop so the alarm is never lost.
          if (tick && tens == 4'd0 && ones == 4'd1) begin
            state_n = EXPIRED;
            done_n  = 1'b1;
          end else if (stop_edge) begin
            state_n = PAUSE;
          end
        end
        PAUSE: begin
          if (start_edge && !stop_edge) state_n = RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tens       <= 4'd0;
      ones       <= 4'd0;
      start_prev <= 1'b0;
      stop_prev  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      tens       <= tens_n;
      ones       <= ones_n;
      start_prev <= start;
      stop_prev  <= stop;
      done       <= done_n;
    end
  end

  assign running = (state == RUN);
  assign alarm   = (state == EXPIRED);

`ifdef COUNTDOWN_ALARM_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;
  logic          blank;

  // Held clear outside EXPIRED so every expiry starts on the "00" phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blank     <= 1'b0;
    end else if (state != EXPIRED) begin
      blink_cnt <= '0;
      blank     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blank     <= ~blank;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign seg1 = blank ? SEG_BLANK : seg_encode(tens);
  assign seg0 = blank ? SEG_BLANK : seg_encode(ones);
`else
  assign seg1 = seg_encode(tens);
  assign seg0 = seg_encode(ones);
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench: stimulus queues cycle-stamped expectations, a negedge monitor compares.
module tb_countdown_timer;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
`ifdef COUNTDOWN_ALARM_BLINK_EN
  localparam logic [6:0] SX = 7'b1111111;
`else
  localparam logic [6:0] SX = 7'b1000000;
`endif

  logic       clk = 1'b0;
  logic       rst, load, start, stop;
  logic [3:0] preset_tens, preset_ones;
  logic [6:0] seg1, seg0;
  logic       running, done, alarm;

  countdown_timer #(.CLK_HZ(10), .BLINK_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .preset_tens (preset_tens),
    .preset_ones (preset_ones),
    .start       (start),
    .stop        (stop),
    .seg1        (seg1),
    .seg0        (seg0),
    .running     (running),
    .done        (done),
    .alarm       (alarm)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [6:0]  s1;
    logic [6:0]  s0;
    logic        run;
    logic        dn;
    logic        al;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  bit   flush  = 1'b0;

  always @(negedge clk) begin
    while (q.size() > 0 && (flush || q[0].cyc <= cyc)) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: sampled at cycle %0d, required at cycle %0d", e.name, cyc, e.cyc);
      end else if (seg1 !== e.s1 || seg0 !== e.s0 || running !== e.run ||
                   done !== e.dn || alarm !== e.al) begin
        errors++;
        $display("FAIL %s: got seg1=%b seg0=%b running=%b done=%b alarm=%b, required seg1=%b seg0=%b running=%b done=%b alarm=%b",
                 e.name, seg1, seg0, running, done, alarm, e.s1, e.s0, e.run, e.dn, e.al);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input string name, input int unsigned dc,
                           input logic [6:0] s1, input logic [6:0] s0,
                           input logic r, input logic d, input logic a);
    exp_t x;
    x.cyc = cyc + dc; x.name = name;
    x.s1 = s1; x.s0 = s0; x.run = r; x.dn = d; x.al = a;
    q.push_back(x);
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    load = 1'b1; preset_tens = t; preset_ones = o;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
    preset_tens = 4'd0; preset_ones = 4'd0;
    step(1);
    expect_at("reset", 0, S0, S0, 0, 0, 0);
    step(1);
    rst = 1'b0;

    // 03 countdown to expiry, then the blink/steady display.
    do_load(4'd0, 4'd3);
    expect_at("load03", 0, S0, S3, 0, 0, 0);
    start = 1'b1; step(1); start = 1'b0;
    expect_at("run_entry", 0, S0, S3, 1, 0, 0);
    expect_at("a_pre_tick", 9, S0, S3, 1, 0, 0);
    expect_at("a_tick1", 10, S0, S2, 1, 0, 0);
    expect_at("a_tick2", 20, S0, S1, 1, 0, 0);
    expect_at("a_pre_expire", 29, S0, S1, 1, 0, 0);
    expect_at("a_expire", 30, S0, S0, 0, 1, 1);
    expect_at("a_done_end", 31, S0, S0, 0, 0, 1);
    expect_at("blink_on_last", 33, S0, S0, 0, 0, 1);
    expect_at("blink_off_first", 34, SX, SX, 0, 0, 1);
    expect_at("blink_off_last", 37, SX, SX, 0, 0, 1);
    expect_at("blink_on_again", 38, S0, S0, 0, 0, 1);
    step(40);
    start = 1'b1; step(1); start = 1'b0;
    expect_at("expired_start_ignored", 0, S0, S0, 0, 0, 1);

    // 10 -> 09 borrow; load also clears the alarm.
    do_load(4'd1, 4'd0);
    expect_at("load10_alarm_clr", 0, S1, S0, 0, 0, 0);
    start = 1'b1; step(1); start = 1'b0;
    expect_at("b_pre_tick", 9, S1, S0, 1, 0, 0);
    expect_at("b_borrow", 10, S0, S9, 1, 0, 0);
    step(10);

    // Pause with divider at 5; resume decrements 5 cycles later.
    do_load(4'd0, 4'd5);
    start = 1'b1; step(1); start = 1'b0;
    expect_at("c_tick", 10, S0, S4, 1, 0, 0);
    step(14);
    expect_at("c_pre_stop", 0, S0, S4, 1, 0, 0);
    stop = 1'b1; step(1); stop = 1'b0;
    expect_at("c_paused", 0, S0, S4, 0, 0, 0);
    step(50);
    expect_at("c_hold", 0, S0, S4, 0, 0, 0);
    start = 1'b1; step(1); start = 1'b0;
    expect_at("c_resume", 0, S0, S4, 1, 0, 0);
    expect_at("c_pre_resume_tick", 4, S0, S4, 1, 0, 0);
    expect_at("c_resume_tick", 5, S0, S3, 1, 0, 0);
    step(6);

    // Coincident start/stop edges while running: stop wins.
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    expect_at("both_edges_pause", 0, S0, S3, 0, 0, 0);
    step(3);
    expect_at("both_edges_hold", 0, S0, S3, 0, 0, 0);

    // Start at 00 is ignored.
    do_load(4'd0, 4'd0);
    start = 1'b1; step(1); start = 1'b0;
    expect_at("zero_start", 0, S0, S0, 0, 0, 0);
    step(12);
    expect_at("zero_idle", 0, S0, S0, 0, 0, 0);

    // Saturation, and a start edge coinciding with load is dropped.
    load = 1'b1; preset_tens = 4'hC; preset_ones = 4'h7; start = 1'b1;
    step(1);
    load = 1'b0;
    expect_at("sat_c7", 0, S9, S7, 0, 0, 0);
    step(1);
    expect_at("load_edge_ignored", 0, S9, S7, 0, 0, 0);
    start = 1'b0;

    // Load while running returns to IDLE with a cleared divider.
    step(1);
    start = 1'b1; step(1); start = 1'b0;
    expect_at("e_run", 0, S9, S7, 1, 0, 0);
    step(3);
    do_load(4'hF, 4'hA);
    expect_at("e_load_fa", 0, S9, S9, 0, 0, 0);
    start = 1'b1; step(1); start = 1'b0;
    expect_at("e_pre_tick", 9, S9, S9, 1, 0, 0);
    expect_at("e_tick", 10, S9, S8, 1, 0, 0);
    step(12);

    // Reset between clock edges must clear the display immediately.
    rst = 1'b1;
    expect_at("async_rst", 0, S0, S0, 0, 0, 0);
    step(1);
    rst = 1'b0;
    step(2);

    flush = 1'b1;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Two-digit seconds countdown timer, the down-counting counterpart of the stopwatch on the same board. Loads a BCD preset of 00–99 and counts down once per second after a start button edge. Pauses on a stop edge and flags expiry at 00. Drives two common-anode 7-segment digits with the same segment encoding as the rest of the display path.

Parameters:
CLK_HZ, 50_000_000, input clock frequency; one tick = exactly CLK_HZ clk cycles
BLINK_DIV, 25_000_000, half-period in cycles of the expiry blink (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
load  in  1  level; loads preset digits, highest priority after rst
preset_tens  in  4  BCD tens digit of preset
preset_ones  in  4  BCD ones digit of preset
start  in  1  start button, rising-edge detected internally
stop  in  1  stop button, rising-edge detected internally
seg1  out  7  tens digit segments, common anode (active-low), bit order g..a
seg0  out  7  ones digit segments, same encoding
running  out  1  high while in RUN
done  out  1  one-cycle pulse on reaching 00
alarm  out  1  level, high in EXPIRED

Behaviour:
- Reset: state IDLE, digits 0/0, divider 0, edge regs 0; seg1=seg0=7'b1000000, running=0, done=0, alarm=0.
- Start/stop edge detection: registered previous values. Edge = in & ~prev.
- States and transitions:
  - IDLE: start edge with count≠00 → RUN. Start edge at 00 is ignored.
  - RUN: stop edge → PAUSE.
  - PAUSE: start edge → RUN.
  - EXPIRED: left only by load or rst.
- Simultaneous start and stop edges in the same cycle: stop wins.
  - IDLE/PAUSE: no transition.
  - RUN: → PAUSE.
- Divider:
  - Counts 0..CLK_HZ-1, only in RUN. Tick asserted in the cycle the divider equals CLK_HZ-1; divider wraps to 0.
  - Divider holds its value in PAUSE, so resumed time is not lost.
  - Divider is cleared by load and by entering IDLE.
- On tick, BCD decrement:
  - ones>0: ones-1.
  - Otherwise ones=9, tens-1.
  - Reaching 00 (from 01): state → EXPIRED the same cycle, done pulses 1 cycle, alarm=1 from the next cycle.
  - No wrap below 00.
- Load (level, sampled every cycle, any state): digits ← preset, state → IDLE, divider ← 0, alarm ← 0. Start/stop edges in a load cycle are ignored.
- Preset digits >9 saturate to 9 (e.g. preset 0xC7 loads 97).
- Reset mid-count returns to the reset values immediately (asynchronously).
- Latency:
  - Start edge registered → RUN one cycle after the button rises.
  - First decrement exactly CLK_HZ cycles after entering RUN from a cleared divider.
  - seg outputs are combinational from the digit registers: zero extra latency.
- Segment encoding (gfedcba, active-low), digits 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.

Optional Feature:
COUNTDOWN_ALARM_BLINK_EN
- Defined: in EXPIRED, both digits alternate between "00" and blank (7'b1111111) every BLINK_DIV cycles, starting with "00" on entry. The blink counter is cleared on leaving EXPIRED.
- Not defined: EXPIRED shows a steady "00", no blink counter is instantiated, and BLINK_DIV is unused.

Decomposition:
- Shared package timer_pkg holds:
  - the state enum {IDLE, RUN, PAUSE, EXPIRED};
  - SEG_BLANK = 7'b1111111;
  - the 10-entry common-anode segment constant array, shared with the stopwatch.
- One sub-module, tick_gen (parameter CLK_HZ):
  - inputs en and clr;
  - output tick;
  - instantiated once for the 1 s tick.

Test Plan (CLK_HZ=10, BLINK_DIV=4 in sim):
- Load 03, start edge → running=1 next cycle; digits 02/01/00 at 10/20/30 cycles after RUN entry; done one cycle at 00; alarm=1; seg0=1000000.
- Load 10, run to 1 tick → digits 09 (borrow), seg1=1000000, seg0=0010000.
- Load 05, start, stop after 15 cycles (count 04, divider 5), wait 50, start → next decrement exactly 5 cycles after re-entering RUN.
- Load 00, start edge → stays IDLE, running=0. Separately, start and stop rising in the same cycle while in RUN → PAUSE.
- Load 0xFA while running → IDLE, digits 99, alarm cleared. Assert rst mid-count → seg1=seg0=1000000 without waiting for a clk edge.
- With COUNTDOWN_ALARM_BLINK_EN: after expiry, seg0 is 1000000 for 4 cycles, then 1111111 for 4, repeating. Without the macro: steady 1000000.
